tick_timer: RTL
===============

// Module: tick_timer
// PURPOSE
//  Parametrised, single-clock successor to the game timer counter. Derives its own tick
//  from clk_50M with an internal prescaler, so no second clock domain is needed.
//  Counts ticks up to a programmable limit and flags completion (e.g. the 2 s dealer delay).
//  Runs either one-shot or periodic. Sits between the BlackJack FSM and the display/delay logic.
// PARAMETERS
//  WIDTH    12          width of tick counter and limit
//  CLK_HZ   50_000_000  frequency of clk_50M
//  TICK_HZ  2_000       tick rate; DIV = CLK_HZ/TICK_HZ, integer >= 1 (elaboration error otherwise)
// PORTS
//  clk_50M  in   1      system clock; all logic on rising edge
//  i_Reset  in   1      asynchronous, active-high reset
//  i_Start  in   1      1-cycle pulse: latch i_Limit and (re)start from 0
//  i_Clear  in   1      synchronous clear: count 0, return to IDLE
//  i_Hold   in   1      level: freeze prescaler and count while RUN
//  i_Mode   in   1      0 = one-shot, 1 = periodic; sampled with i_Start
//  i_Limit  in   WIDTH  terminal tick count; sampled with i_Start
//  o_Count  out  WIDTH  current tick count (registered)
//  o_Tick   out  1      1-cycle pulse in every cycle o_Count changes due to a tick
//  o_Done   out  1      1-cycle pulse when the count reaches the limit
//  o_Busy   out  1      high while in RUN
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-run): state IDLE; prescaler, o_Count, o_Tick, o_Done,
//    o_Busy, latched limit and mode all 0. Outputs are registered, never glitch.
//  - States:
//    IDLE: count held.
//    RUN: prescaler 0..DIV-1.
//  - IDLE, i_Start: latch limit/mode, prescaler <= 0, count <= 0, go RUN (o_Busy=1 next cycle).
//  - RUN, i_Start: restart identically (re-latch, clear count and prescaler); no o_Done.
//  - RUN, i_Hold=1, no Start/Clear: all state frozen; o_Tick/o_Done stay 0.
//  - RUN tick: prescaler==DIV-1 and i_Hold=0 -> prescaler <= 0.
//    If count+1 != limit: count <= count+1, o_Tick=1 next cycle.
//    If count+1 == limit, one-shot: count <= limit, o_Tick=1, o_Done=1, go IDLE
//      (o_Busy=0 in that same cycle); count holds limit.
//    If count+1 == limit, periodic: count <= 0, o_Tick=1, o_Done=1, stay RUN.
//  - Latency: the first tick lands DIV clocks after the Start edge, then every DIV clocks
//    (plus held cycles). o_Done for limit L lands L*DIV clocks after the Start edge.
//  - i_Limit == 0 at Start: no run; next cycle o_Done=1, count=0, state IDLE, o_Busy=0.
//  - Priority in one cycle: i_Clear > i_Start > i_Hold > tick.
//    Clear+Start together -> IDLE, count 0, no o_Done.
//  - Count width: limit <= 2^WIDTH-1, so the count never wraps past the limit.
//    i_Limit/i_Mode changes after Start have no effect until the next Start.
//  - DIV == 1: tick every RUN cycle.
// TESTING (bench: CLK_HZ=10, TICK_HZ=2 -> DIV=5, WIDTH=4)
//  1 Reset asserted mid-clock -> all outputs 0 immediately; after release, IDLE, o_Count=0.
//  2 One-shot, i_Limit=3, Start at edge T -> o_Tick at T+5, T+10, T+15.
//    o_Count goes 1, 2, 3; o_Done high only at T+15; o_Busy low from T+15; count holds 3.
//  3 Periodic, i_Limit=2 -> o_Count sequence 1,0,1,0 at T+5/10/15/20.
//    o_Done at T+10 and T+20; o_Busy stays 1.
//  4 One-shot limit 2, i_Hold high for 7 cycles starting T+3 -> o_Done at T+17, not T+10.
//  5 Clear and Start in the same cycle during RUN -> IDLE, count 0, no o_Done.
//    Start re-asserted at count 2 -> count 0 and full L*DIV period restarts.
//  6 Start with i_Limit=0 -> o_Done pulse 1 cycle later, o_Busy never high.
//    Start with limit 15 (max) -> o_Done at T+75, count 15.

Source files
------------

// File: rtl/tick_timer.sv
// Prescaled tick counter: counts ticks of CLK_HZ/TICK_HZ up to a latched limit, one-shot or periodic.
// First tick DIV clocks after Start, o_Done L*DIV clocks after Start; i_Hold freezes the run.
module tick_timer #(
   parameter int WIDTH   = 12,
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 2_000
) (
   input  logic             clk_50M,
   input  logic             i_Reset,
   input  logic             i_Start,
   input  logic             i_Clear,
   input  logic             i_Hold,
   input  logic             i_Mode,
   input  logic [WIDTH-1:0] i_Limit,
   output logic [WIDTH-1:0] o_Count,
   output logic             o_Tick,
   output logic             o_Done,
   output logic             o_Busy
);

   localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 1;
   localparam int REM = (TICK_HZ > 0) ? (CLK_HZ % TICK_HZ) : 1;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   generate
      if (TICK_HZ < 1 || REM != 0 || CLK_HZ < TICK_HZ) begin : g_bad_div
         $error("tick_timer: CLK_HZ/TICK_HZ must be an integer >= 1");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   logic [PW-1:0]     r_presc;
   logic [WIDTH-1:0]  r_count;
   logic [WIDTH-1:0]  r_limit;
   logic              r_mode;
   logic              r_tick;
   logic              r_done;

   state_t            w_state_nxt;
   logic [PW-1:0]     w_presc_nxt;
   logic [WIDTH-1:0]  w_count_nxt;
   logic [WIDTH-1:0]  w_limit_nxt;
   logic              w_mode_nxt;
   logic              w_tick_nxt;
   logic              w_done_nxt;
   logic [WIDTH-1:0]  w_count_inc;
   logic              w_advance;

   assign w_count_inc = r_count + WIDTH'(1);
   assign w_advance   = (r_state == S_RUN) && !i_Hold;

   always_ff @(posedge clk_50M or posedge i_Reset) begin
      if (i_Reset) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_count <= '0;
         r_limit <= '0;
         r_mode  <= 1'b0;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_count <= w_count_nxt;
         r_limit <= w_limit_nxt;
         r_mode  <= w_mode_nxt;
         r_tick  <= w_tick_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_count_nxt = r_count;
      w_limit_nxt = r_limit;
      w_mode_nxt  = r_mode;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = 1'b0;

      if (i_Clear) begin
         w_state_nxt = S_IDLE;
         w_presc_nxt = '0;
         w_count_nxt = '0;
      end else if (i_Start) begin
         w_limit_nxt = i_Limit;
         w_mode_nxt  = i_Mode;
         w_presc_nxt = '0;
         w_count_nxt = '0;
         // A zero limit is already reached: report completion without running.
         if (i_Limit == '0) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
         end else begin
            w_state_nxt = S_RUN;
         end
      end else if (w_advance && (r_presc == PRESC_MAX)) begin
         w_presc_nxt = '0;
         w_tick_nxt  = 1'b1;
         if (w_count_inc != r_limit) begin
            w_count_nxt = w_count_inc;
         end else begin
            w_done_nxt = 1'b1;
            if (r_mode) begin
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_limit;
               w_state_nxt = S_IDLE;
            end
         end
      end else if (w_advance) begin
         w_presc_nxt = r_presc + PW'(1);
      end
   end

   assign o_Count = r_count;
   assign o_Tick  = r_tick;
   assign o_Done  = r_done;
   assign o_Busy  = (r_state == S_RUN);

endmodule
